// File: rtl/execute_stage_if.sv
// EX-stage bus: ID/EX inputs toward EX, EX/MEM outputs toward MEM.
// master = upstream/hazard/MEM side, slave = execute_stage.
interface execute_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
);
  logic              validE;
  logic              flushE;
  logic              regWriteE;
  logic              memWriteE;
  logic [1:0]        resultSrcE;
  logic [3:0]        aluControlE;
  logic [DATA_W-1:0] srcAE;
  logic [DATA_W-1:0] srcBE;
  logic [DATA_W-1:0] writeDataE;
  logic [DATA_W-1:0] PCPlus2E;
  logic [REG_W-1:0]  RdE;
  logic              zeroE;
  logic              stallE;
  logic              regWriteM;
  logic              memWriteM;
  logic [1:0]        resultSrcM;
  logic [DATA_W-1:0] aluResM;
  logic [DATA_W-1:0] writeDataM;
  logic [DATA_W-1:0] PCPlus2M;
  logic [REG_W-1:0]  RdM;

  modport master (
    output validE, flushE, regWriteE, memWriteE,
    output resultSrcE, aluControlE, srcAE, srcBE,
    output writeDataE, PCPlus2E, RdE,
    input  zeroE, stallE, regWriteM, memWriteM,
    input  resultSrcM, aluResM, writeDataM,
    input  PCPlus2M, RdM
  );

  modport slave (
    input  validE, flushE, regWriteE, memWriteE,
    input  resultSrcE, aluControlE, srcAE, srcBE,
    input  writeDataE, PCPlus2E, RdE,
    output zeroE, stallE, regWriteM, memWriteM,
    output resultSrcM, aluResM, writeDataM,
    output PCPlus2M, RdM
  );
endinterface

// File: rtl/execute_stage.sv
// EX stage: 1-cycle ALU, 16-iteration MUL/DIVU/REMU unit, EX/MEM register.
// Ports: clk, rst (async high), bus (execute_stage_if.slave).
module execute_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  execute_stage_if.slave  bus
);
  localparam int CW = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;
  localparam logic [3:0] OP_REMU = 4'd11;

  typedef enum logic [1:0] {
    IDLE, BUSY, DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [3:0]        op_q;
  // MUL: a=acc, b=multiplicand, c=multiplier
  // DIV: a=remainder, b=divisor, c=dividend/quotient
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic [DATA_W-1:0] a_d, b_d, c_d;

  logic [DATA_W-1:0] a, b, alu, res, md_res;
  logic [CW-1:0]     sh;
  logic              is_md, start, load;
  logic [DATA_W:0]   trial;
  logic              ge;

  assign a  = bus.srcAE;
  assign b  = bus.srcBE;
  assign sh = b[CW-1:0];

  always_comb begin
    alu = b;
    unique case (bus.aluControlE)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_SLL:  alu = a << sh;
      OP_SRL:  alu = a >> sh;
      OP_SRA:  alu = $signed(a) >>> sh;
      OP_SLT:  alu = {{(DATA_W-1){1'b0}},
                      $signed(a) < $signed(b)};
      default: alu = b;
    endcase
  end

  assign is_md = (bus.aluControlE == OP_MUL)
              || (bus.aluControlE == OP_DIVU)
              || (bus.aluControlE == OP_REMU);
  assign start = bus.validE && is_md && !bus.flushE;

  assign bus.zeroE  = !is_md && (alu == '0);
  assign bus.stallE = !rst &&
    ((state_q == IDLE && start) || state_q == BUSY);

  // Restoring divide step. Divisor 0 always "fits", giving an
  // all-ones quotient and the dividend as remainder.
  assign trial = {a_q, c_q[DATA_W-1]};
  assign ge    = trial >= {1'b0, b_q};

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    if (op_q == OP_MUL) begin
      a_d = a_q + (c_q[0] ? b_q : '0);
      b_d = b_q << 1;
      c_d = c_q >> 1;
    end else begin
      a_d = ge ? (trial[DATA_W-1:0] - b_q)
               : trial[DATA_W-1:0];
      c_d = {c_q[DATA_W-2:0], ge};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_q <= BUSY;
          cnt_q   <= '0;
          op_q    <= bus.aluControlE;
          a_q     <= '0;
          if (bus.aluControlE == OP_MUL) begin
            b_q <= a;
            c_q <= b;
          end else begin
            b_q <= b;
            c_q <= a;
          end
        end
        BUSY: if (bus.flushE) begin
          state_q <= IDLE;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          c_q   <= c_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_W-1))
            state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md_res = (op_q == OP_DIVU) ? c_q : a_q;
  assign res    = (state_q == DONE) ? md_res : alu;
  assign load   = bus.validE && !bus.flushE && !bus.stallE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.regWriteM  <= 1'b0;
      bus.memWriteM  <= 1'b0;
      bus.resultSrcM <= '0;
      bus.aluResM    <= '0;
      bus.writeDataM <= '0;
      bus.PCPlus2M   <= '0;
      bus.RdM        <= '0;
    end else if (load) begin
      bus.regWriteM  <= bus.regWriteE;
      bus.memWriteM  <= bus.memWriteE;
      bus.resultSrcM <= bus.resultSrcE;
      bus.aluResM    <= res;
      bus.writeDataM <= bus.writeDataE;
      bus.PCPlus2M   <= bus.PCPlus2E;
      bus.RdM        <= bus.RdE;
    end else begin
      bus.regWriteM  <= 1'b0;
      bus.memWriteM  <= 1'b0;
      bus.resultSrcM <= '0;
      bus.aluResM    <= '0;
      bus.writeDataM <= '0;
      bus.PCPlus2M   <= '0;
      bus.RdM        <= '0;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage.
// Drives on falling edge, samples registered outputs one edge later.
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  execute_stage_if #(.DATA_W(16), .REG_W(4)) bus ();

  execute_stage #(.DATA_W(16), .REG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic fl,
                       input logic [3:0] op,
                       input logic [15:0] sa, input logic [15:0] sb,
                       input logic [3:0] rd);
    bus.validE      = v;
    bus.flushE      = fl;
    bus.regWriteE   = 1'b1;
    bus.memWriteE   = 1'b0;
    bus.resultSrcE  = 2'b01;
    bus.aluControlE = op;
    bus.srcAE       = sa;
    bus.srcBE       = sb;
    bus.writeDataE  = 16'hA5A5;
    bus.PCPlus2E    = 16'h0102;
    bus.RdE         = rd;
  endtask

  task automatic run_md(input string tag, input logic [3:0] op,
                        input logic [15:0] sa, input logic [15:0] sb,
                        input logic [15:0] exp);
    int cnt = 0;
    drive(1'b1, 1'b0, op, sa, sb, 4'd5);
    #1;
    while (bus.stallE && cnt < 40) begin
      if (cnt > 0) check({tag, "_bubble"}, 32'(bus.regWriteM), 0);
      cnt++;
      @(negedge clk); #1;
    end
    check({tag, "_stall_cycles"}, cnt, 17);
    @(negedge clk); #1;
    check({tag, "_res"}, 32'(bus.aluResM), 32'(exp));
    check({tag, "_rw"}, 32'(bus.regWriteM), 1);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 4'd0);
    @(negedge clk); @(negedge clk);
    check("rst_alures", 32'(bus.aluResM), 0);
    check("rst_rw", 32'(bus.regWriteM), 0);
    check("rst_stall", 32'(bus.stallE), 0);
    rst = 1'b0;

    // ADD overflow wrap
    drive(1'b1, 1'b0, 4'd0, 16'h7FFF, 16'h0001, 4'd3);
    #1;
    check("add_zero", 32'(bus.zeroE), 0);
    @(negedge clk); #1;
    check("add_res", 32'(bus.aluResM), 32'h8000);
    check("add_rd", 32'(bus.RdM), 3);
    check("add_rw", 32'(bus.regWriteM), 1);
    check("add_wd", 32'(bus.writeDataM), 32'hA5A5);
    check("add_pc", 32'(bus.PCPlus2M), 32'h0102);
    check("add_rs", 32'(bus.resultSrcM), 1);

    drive(1'b1, 1'b0, 4'd1, 16'd5, 16'd5, 4'd4);
    #1;
    check("sub_zero", 32'(bus.zeroE), 1);
    @(negedge clk); #1;
    check("sub_res", 32'(bus.aluResM), 0);

    drive(1'b1, 1'b0, 4'd7, 16'h8010, 16'd4, 4'd4);
    @(negedge clk); #1;
    check("sra_res", 32'(bus.aluResM), 32'hF801);

    drive(1'b1, 1'b0, 4'd8, 16'hFFFF, 16'd1, 4'd4);
    @(negedge clk); #1;
    check("slt_res", 32'(bus.aluResM), 1);

    drive(1'b0, 1'b0, 4'd0, 16'd1, 16'd1, 4'd4);
    @(negedge clk); #1;
    check("bubble_rw", 32'(bus.regWriteM), 0);

    run_md("mul", 4'd9, 16'h0123, 16'h0045, 16'h4E6F);
    run_md("divu", 4'd10, 16'd100, 16'd7, 16'd14);
    run_md("remu", 4'd11, 16'd100, 16'd7, 16'd2);
    run_md("divu0", 4'd10, 16'd9, 16'd0, 16'hFFFF);
    run_md("remu0", 4'd11, 16'd9, 16'd0, 16'd9);

    // flush wins over starting a multi-cycle op
    drive(1'b1, 1'b1, 4'd9, 16'd3, 16'd3, 4'd2);
    #1;
    check("flush_start_stall", 32'(bus.stallE), 0);
    @(negedge clk); #1;
    check("flush_start_rw", 32'(bus.regWriteM), 0);

    // flush at BUSY iteration 5
    drive(1'b1, 1'b0, 4'd9, 16'd3, 16'd3, 4'd2);
    repeat (6) @(negedge clk);
    bus.flushE = 1'b1;
    #1;
    check("flush_busy_stall", 32'(bus.stallE), 1);
    @(negedge clk); #1;
    check("flush_after_stall", 32'(bus.stallE), 0);
    check("flush_after_rw", 32'(bus.regWriteM), 0);
    drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0);
    @(negedge clk);

    // reset mid-BUSY
    drive(1'b1, 1'b0, 4'd9, 16'h0123, 16'h0045, 4'd6);
    repeat (5) @(negedge clk);
    #1;
    check("pre_rst_stall", 32'(bus.stallE), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_stall", 32'(bus.stallE), 0);
    check("rst_mid_res", 32'(bus.aluResM), 0);
    check("rst_mid_rd", 32'(bus.RdM), 0);
    check("rst_mid_rw", 32'(bus.regWriteM), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0);
    repeat (20) @(negedge clk);
    #1;
    check("post_rst_res", 32'(bus.aluResM), 0);
    check("post_rst_stall", 32'(bus.stallE), 0);

    drive(1'b1, 1'b0, 4'd0, 16'd2, 16'd3, 4'd1);
    @(negedge clk); #1;
    check("add_after_rst", 32'(bus.aluResM), 5);
    check("add_after_rst_rw", 32'(bus.regWriteM), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage of the 16-bit pipelined core; sits directly upstream of the memory stage and drives its inputs through the EX/MEM pipeline register.
- Single-cycle ALU handles arithmetic, logic, shift and compare operations.
- Iterative 16-cycle multiply/divide unit handles MUL, DIVU and REMU, and stalls the front of the pipe while it runs.
- Registered outputs feed the memory stage ports of the same names.

Parameters:
- DATA_W, 16, datapath width; the multiply/divide iteration count equals DATA_W.
- REG_W, 4, destination register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- validE  in  1  EX holds a real instruction; 0 = bubble.
- flushE  in  1  kill the instruction in EX (branch redirect).
- regWriteE  in  1  register write enable from ID/EX.
- memWriteE  in  1  memory write enable from ID/EX.
- resultSrcE  in  2  writeback mux select, passed through.
- aluControlE  in  4  operation code.
- srcAE  in  DATA_W  operand A (already forwarded).
- srcBE  in  DATA_W  operand B (already forwarded).
- writeDataE  in  DATA_W  store data, passed through.
- PCPlus2E  in  DATA_W  PC+2, passed through.
- RdE  in  REG_W  destination register.
- zeroE  out  1  combinational: ALU result == 0 (single-cycle ops only); for branch resolution.
- stallE  out  1  combinational: multiply/divide in progress; hazard unit freezes IF/ID/EX.
- regWriteM  out  1  registered.
- memWriteM  out  1  registered.
- resultSrcM  out  2  registered.
- aluResM  out  DATA_W  registered.
- writeDataM  out  DATA_W  registered.
- PCPlus2M  out  DATA_W  registered.
- RdM  out  REG_W  registered.

Behaviour:
- Reset (asynchronous, active-high):
  - All registered outputs go to 0.
  - FSM goes to IDLE, iteration counter to 0.
  - stallE=0 while rst is high.
  - A multiply/divide in flight is abandoned; no partial result ever reaches the M outputs.
- aluControlE encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount = srcBE[3:0].
  - 8 SLT: signed; result 16'h0001 or 16'h0000.
  - 9 MUL: low DATA_W bits of the product.
  - 10 DIVU: unsigned quotient.
  - 11 REMU: unsigned remainder.
  - 12–15 pass srcBE.
  - All arithmetic is modulo 2^DATA_W; no flags other than zeroE.
- Divide by zero: DIVU returns 16'hFFFF; REMU returns srcAE. Takes the same latency as a normal divide.
- FSM for MUL/DIVU/REMU (states IDLE, BUSY, DONE):
  - IDLE + validE + multi-cycle op + !flushE: stallE=1; at the clock edge, latch operands and op, counter=0, go to BUSY.
  - BUSY: stallE=1; one iteration per cycle (shift-add multiply, restoring divide). After 16 iterations go to DONE.
  - DONE: stallE=0; result drives the EX/MEM aluRes input; EX/MEM captures at that edge; FSM returns to IDLE.
  - Latency: stallE high for 17 cycles; aluResM updates at the 18th edge after the op enters EX.
- Upstream holds all E inputs stable while stallE=1. The FSM uses latched operands, so instability does not corrupt the result.
- EX/MEM register loading:
  - While stallE=1: load a bubble (regWriteM=0, memWriteM=0; other fields don't-care but deterministic, held at 0).
  - flushE=1 or validE=0: load a bubble.
  - Otherwise: load all pass-through fields plus the selected result.
- flushE during BUSY or DONE: FSM returns to IDLE at the next edge, bubble loaded, stallE low from the next cycle.
- flushE has priority over starting a new multi-cycle op.
- Back-to-back multi-cycle ops: the second op starts from IDLE one cycle after DONE; there is no overlap.

Test Plan:
- Reset then ADD, srcA=16'h7FFF, srcB=16'h0001, RdE=3, regWriteE=1:
  - Next edge: aluResM=16'h8000, RdM=3, regWriteM=1.
  - zeroE=0 before that edge.
- SUB 5−5:
  - zeroE=1 combinationally.
  - aluResM=0 next edge.
- SRA 16'h8010 by srcB=4:
  - aluResM=16'hF801.
- MUL 16'h0123×16'h0045:
  - stallE=1 for exactly 17 cycles; regWriteM=0 throughout.
  - Then aluResM=16'h4E6F, regWriteM=1.
- DIVU 100/7 → aluResM=14; REMU 100/7 → aluResM=2.
- DIVU 9/0 → 16'hFFFF; REMU 9/0 → 9.
- Abort cases:
  - flushE asserted at BUSY iteration 5: stallE low next cycle; bubble in M (regWriteM=0).
  - rst pulsed mid-BUSY: all M outputs 0 immediately; stallE=0.
  - A subsequent ADD 2+3 yields aluResM=5 next edge.
